// File: rtl/gba_timer_pkg.sv
// Shared types and constants for the four-channel timer block.
// Latency: n/a (package only).
// Backpressure: n/a; writes are one-cycle strobes that are always accepted.
package gba_timer_pkg;

  localparam int NUM_TIMERS = 4;

  // Prescale selection as encoded in control bits [1:0].
  typedef enum logic [1:0] {
    PRESC_1    = 2'd0,
    PRESC_64   = 2'd1,
    PRESC_256  = 2'd2,
    PRESC_1024 = 2'd3
  } prescale_e;

  localparam int unsigned PERIOD_1    = 1;
  localparam int unsigned PERIOD_64   = 64;
  localparam int unsigned PERIOD_256  = 256;
  localparam int unsigned PERIOD_1024 = 1024;

  // Control word bit positions; all other bits are discarded on write.
  localparam int CTRL_PRESC_LSB = 0;
  localparam int CTRL_COUNT_UP  = 2;
  localparam int CTRL_IRQ_EN    = 6;
  localparam int CTRL_ENABLE    = 7;

  // Only the meaningful control fields are stored.
  typedef struct packed {
    logic      enable;
    logic      irq_en;
    logic      count_up;
    prescale_e prescale;
  } ctrl_t;

  // Terminal value of the 10-bit prescale counter for a given selection.
  function automatic logic [9:0] prescale_last(input prescale_e p);
    case (p)
      PRESC_1:    return 10'(PERIOD_1 - 1);
      PRESC_64:   return 10'(PERIOD_64 - 1);
      PRESC_256:  return 10'(PERIOD_256 - 1);
      default:    return 10'(PERIOD_1024 - 1);
    endcase
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer: reload/control registers, 10-bit prescaler, 16-bit counter, wrap detect.
// Latency: counter and overflow update on the edge of the tick; wrap is combinational for cascading.
// Backpressure: none; register writes take effect at the edge they are presented.
module timer_channel
  import gba_timer_pkg::*;
#(
  parameter bit CASCADE_OK = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_reload,
  input  logic        wr_ctrl,
  input  logic [15:0] wr_data,
  input  logic        cascade_in,
  output logic [15:0] count,
  output logic        wrap,
  output logic        overflow,
  output logic        irq
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] reload_q, reload_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [9:0]  pre_q, pre_d;
  logic        ovf_q, ovf_d;

  logic running, cascade_mode, pre_hit, starting, stopping, tick;

  // Next-state: register writes, start/stop handling, prescaler and counter stepping.
  always_comb begin
    running      = ctrl_q.enable;
    cascade_mode = CASCADE_OK & ctrl_q.count_up;
    pre_hit      = (pre_q == prescale_last(ctrl_q.prescale));

    // A reload written on the wrap edge is the value the wrap loads.
    reload_d = wr_reload ? wr_data : reload_q;

    ctrl_d = ctrl_q;
    if (wr_ctrl) begin
      ctrl_d.enable   = wr_data[CTRL_ENABLE];
      ctrl_d.irq_en   = wr_data[CTRL_IRQ_EN];
      ctrl_d.count_up = wr_data[CTRL_COUNT_UP];
      ctrl_d.prescale = prescale_e'(wr_data[CTRL_PRESC_LSB +: 2]);
    end

    // Disabling freezes immediately; enabling from idle restarts without ticking.
    stopping = wr_ctrl & ~wr_data[CTRL_ENABLE];
    starting = wr_ctrl & wr_data[CTRL_ENABLE] & ~running;

    tick = running & ~stopping & ~starting & (cascade_mode ? cascade_in : pre_hit);
    wrap = tick & (cnt_q == 16'hFFFF);

    cnt_d = cnt_q;
    pre_d = pre_q;
    if (starting) begin
      cnt_d = reload_q;
      pre_d = '0;
    end else if (running && !stopping && !cascade_mode) begin
      pre_d = pre_hit ? 10'd0 : pre_q + 10'd1;
    end
    if (tick) begin
      cnt_d = wrap ? reload_d : cnt_q + 16'd1;
    end

    ovf_d = wrap;
  end

  // State registers; synchronous reset wins over any coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      reload_q <= '0;
      ctrl_q   <= '0;
      pre_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      ctrl_q   <= ctrl_d;
      pre_q    <= pre_d;
      ovf_q    <= ovf_d;
    end
  end

  assign count    = cnt_q;
  assign overflow = ovf_q;
  assign irq      = ovf_q & ctrl_q.irq_en;

endmodule

// File: rtl/timer_unit.sv
// Four cascadable 16-bit timers with write decode; build option TIMER_CASCADE_EN enables count-up chaining.
// Latency: counts/pulses registered one edge after the tick; cascade adds zero cycles between timers.
// Backpressure: none; every write strobe is accepted in its cycle.
module timer_unit
  import gba_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_timer,
  input  logic        wr_sel,
  input  logic [15:0] wr_data,
  output logic [63:0] tm_count,
  output logic [3:0]  timer_irq,
  output logic [3:0]  overflow
);

`ifdef TIMER_CASCADE_EN
  localparam bit CASCADE_BUILD = 1'b1;
`else
  localparam bit CASCADE_BUILD = 1'b0;
`endif

  logic [NUM_TIMERS-1:0] wr_reload, wr_ctrl, ch_wrap, cascade_in;

  // Route the single write port to one channel's reload or control register.
  always_comb begin
    wr_reload = '0;
    wr_ctrl   = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      wr_reload[i] = wr_en & ~wr_sel & (wr_timer == 2'(i));
      wr_ctrl[i]   = wr_en &  wr_sel & (wr_timer == 2'(i));
    end
  end

`ifdef TIMER_CASCADE_EN
  // Each timer may count the previous timer's wrap in the same cycle.
  always_comb begin
    cascade_in = {ch_wrap[NUM_TIMERS-2:0], 1'b0};
  end
`else
  // No inter-timer path: count-up is stored but has no source.
  always_comb begin
    cascade_in = '0;
  end
`endif

  // The last timer's wrap (and, without cascading, every wrap) has no consumer here.
  logic unused_wrap;
  assign unused_wrap = ^ch_wrap;

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    timer_channel #(
      .CASCADE_OK(CASCADE_BUILD && (i != 0))
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_reload (wr_reload[i]),
      .wr_ctrl   (wr_ctrl[i]),
      .wr_data   (wr_data),
      .cascade_in(cascade_in[i]),
      .count     (tm_count[16*i +: 16]),
      .wrap      (ch_wrap[i]),
      .overflow  (overflow[i]),
      .irq       (timer_irq[i])
    );
  end

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit: directed scenarios plus randomized writes against a reference model.
// Latency: model state is advanced at each rising edge and compared 1 time unit later.
// Backpressure: n/a.
module tb_timer_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_timer;
  logic        wr_sel;
  logic [15:0] wr_data;
  logic [63:0] tm_count;
  logic [3:0]  timer_irq;
  logic [3:0]  overflow;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef TIMER_CASCADE_EN
  localparam bit CASC = 1'b1;
`else
  localparam bit CASC = 1'b0;
`endif

  timer_unit dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_timer (wr_timer),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .tm_count (tm_count),
    .timer_irq(timer_irq),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers per timer, updated once per rising edge.
  int unsigned m_cnt[4], m_rel[4], m_ctrl[4], m_elapsed[4];
  bit          m_ovf[4];

  function automatic int unsigned period_of(input int unsigned ctrl);
    case (ctrl & 3)
      0:       return 1;
      1:       return 64;
      2:       return 256;
      default: return 1024;
    endcase
  endfunction

  function automatic void model_edge();
    bit prev_wrap = 1'b0;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_rel[i] = 0; m_ctrl[i] = 0; m_elapsed[i] = 0; m_ovf[i] = 1'b0;
      end
      return;
    end
    for (int i = 0; i < 4; i++) begin
      bit hit_ctl = wr_en && (wr_timer == i) && wr_sel;
      bit hit_rel = wr_en && (wr_timer == i) && !wr_sel;
      int unsigned new_rel = hit_rel ? int'(wr_data) : m_rel[i];
      bit run = ((m_ctrl[i] >> 7) & 1) != 0;
      bit chained = CASC && (i > 0) && (((m_ctrl[i] >> 2) & 1) != 0);
      bit tick = 1'b0;
      bit wrapped;
      if (hit_ctl && !wr_data[7]) begin
        // stopped: nothing moves
      end else if (hit_ctl && !run) begin
        m_cnt[i] = m_rel[i];
        m_elapsed[i] = 0;
      end else if (run) begin
        if (chained) begin
          tick = prev_wrap;
        end else begin
          m_elapsed[i] = m_elapsed[i] + 1;
          if (m_elapsed[i] == period_of(m_ctrl[i])) begin
            tick = 1'b1;
            m_elapsed[i] = 0;
          end
        end
      end
      wrapped = tick && (m_cnt[i] == 32'hFFFF);
      if (tick) m_cnt[i] = wrapped ? new_rel : m_cnt[i] + 1;
      m_rel[i] = new_rel;
      if (hit_ctl) m_ctrl[i] = int'(wr_data) & 32'hC7;
      m_ovf[i] = wrapped;
      prev_wrap = wrapped;
    end
  endfunction

  // Expected {tm_count, overflow, timer_irq} from the model.
  function automatic logic [71:0] exp_vec();
    logic [71:0] v = '0;
    for (int i = 0; i < 4; i++) begin
      v[8 + 16*i +: 16] = m_cnt[i][15:0];
      v[4 + i] = m_ovf[i];
      v[i]     = m_ovf[i] && (((m_ctrl[i] >> 6) & 1) != 0);
    end
    return v;
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_write(input logic [1:0] t, input logic sel, input logic [15:0] d);
    wr_en = 1'b1; wr_timer = t; wr_sel = sel; wr_data = d;
    tick_clk();
    wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0; wr_timer = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick_clk();
    tick_clk();
    n_checks++;
    if ({tm_count, overflow, timer_irq} !== 72'h0) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", {tm_count, overflow, timer_irq}, 72'h0);
    end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) tick_clk();
    n_checks++;
    if ({tm_count, overflow, timer_irq} !== exp_vec()) begin
      n_fail++; $display("FAIL idle_after_reset: got %h expected %h", {tm_count, overflow, timer_irq}, exp_vec());
    end
  endtask

  task automatic test_t0_wrap();
    logic [15:0] want_cnt[4] = '{16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFF};
    logic        want_pulse[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_write(2'd0, 1'b0, 16'hFFFE);
    do_write(2'd0, 1'b1, 16'h00C0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick_clk();
      n_checks++;
      if ({tm_count[15:0], overflow[0], timer_irq[0]} !== {want_cnt[k], want_pulse[k], want_pulse[k]}) begin
        n_fail++;
        $display("FAIL t0_wrap[%0d]: got cnt=%h ovf=%b irq=%b expected cnt=%h ovf=irq=%b",
                 k, tm_count[15:0], overflow[0], timer_irq[0], want_cnt[k], want_pulse[k]);
      end
      n_checks++;
      if ({tm_count, overflow, timer_irq} !== exp_vec()) begin
        n_fail++; $display("FAIL t0_wrap_model[%0d]: got %h expected %h", k, {tm_count, overflow, timer_irq}, exp_vec());
      end
    end
    do_write(2'd0, 1'b1, 16'h0000);
  endtask

  task automatic test_cascade();
    int first_irq = -1;
    do_write(2'd0, 1'b0, 16'hFFFF);
    do_write(2'd1, 1'b0, 16'hFFFE);
    do_write(2'd1, 1'b1, 16'h00C4);
    do_write(2'd0, 1'b1, 16'h0081);
    for (int k = 1; k <= 300; k++) begin
      tick_clk();
      if (timer_irq[1] === 1'b1 && first_irq < 0) first_irq = k;
      if ({tm_count, overflow, timer_irq} !== exp_vec()) begin
        n_checks++; n_fail++;
        $display("FAIL cascade_model[%0d]: got %h expected %h", k, {tm_count, overflow, timer_irq}, exp_vec());
        break;
      end
    end
    n_checks++;
    if (first_irq != (CASC ? 128 : 1)) begin
      n_fail++; $display("FAIL cascade_first_irq1: got cycle %0d expected %0d", first_irq, CASC ? 128 : 1);
    end
    do_write(2'd0, 1'b1, 16'h0000);
    do_write(2'd1, 1'b1, 16'h0000);
  endtask

  task automatic test_disable();
    bit reached = 1'b0;
    do_write(2'd2, 1'b0, 16'h1200);
    do_write(2'd2, 1'b1, 16'h0080);
    for (int k = 0; k < 100; k++) begin
      if (tm_count[47:32] === 16'h1234) begin reached = 1'b1; break; end
      tick_clk();
    end
    n_checks++;
    if (!reached) begin
      n_fail++; $display("FAIL disable_reach: got %h expected %h within 100 cycles", tm_count[47:32], 16'h1234);
    end
    do_write(2'd2, 1'b1, 16'h0000);
    n_checks++;
    for (int k = 0; k < 2000; k++) begin
      if ({tm_count[47:32], overflow[2], timer_irq[2]} !== {16'h1234, 2'b00}) begin
        n_fail++;
        $display("FAIL disable_hold[%0d]: got cnt=%h ovf=%b irq=%b expected 1234 0 0", k, tm_count[47:32], overflow[2], timer_irq[2]);
        break;
      end
      tick_clk();
    end
    do_write(2'd2, 1'b1, 16'h0080);
    n_checks++;
    if (tm_count[47:32] !== 16'h1200) begin
      n_fail++; $display("FAIL disable_restart: got %h expected %h", tm_count[47:32], 16'h1200);
    end
    do_write(2'd2, 1'b1, 16'h0000);
  endtask

  task automatic test_reload_wrap();
    bit reached = 1'b0;
    do_write(2'd3, 1'b0, 16'hFFF0);
    do_write(2'd3, 1'b1, 16'h0080);
    tick_clk();
    tick_clk();
    do_write(2'd3, 1'b0, 16'h5555);
    n_checks++;
    if (tm_count[63:48] !== 16'hFFF3) begin
      n_fail++; $display("FAIL reload_midcount: got %h expected %h", tm_count[63:48], 16'hFFF3);
    end
    for (int k = 0; k < 40; k++) begin
      if (tm_count[63:48] === 16'hFFFF) begin reached = 1'b1; break; end
      tick_clk();
    end
    n_checks++;
    if (!reached) begin
      n_fail++; $display("FAIL reload_reach: got %h expected FFFF within 40 cycles", tm_count[63:48]);
    end
    do_write(2'd3, 1'b0, 16'hAAAA);
    n_checks++;
    if ({tm_count[63:48], overflow[3]} !== {16'hAAAA, 1'b1}) begin
      n_fail++; $display("FAIL reload_on_wrap: got cnt=%h ovf=%b expected cnt=aaaa ovf=1", tm_count[63:48], overflow[3]);
    end
    n_checks++;
    if ({tm_count, overflow, timer_irq} !== exp_vec()) begin
      n_fail++; $display("FAIL reload_model: got %h expected %h", {tm_count, overflow, timer_irq}, exp_vec());
    end
    do_write(2'd3, 1'b1, 16'h0000);
  endtask

  task automatic test_irq_mask();
    do_write(2'd0, 1'b0, 16'hFFFF);
    do_write(2'd0, 1'b1, 16'h0080);
    n_checks++;
    for (int k = 0; k < 50; k++) begin
      tick_clk();
      if ({overflow[0], timer_irq[0], tm_count[15:0]} !== {2'b10, 16'hFFFF}) begin
        n_fail++;
        $display("FAIL irq_mask[%0d]: got ovf=%b irq=%b cnt=%h expected ovf=1 irq=0 cnt=ffff", k, overflow[0], timer_irq[0], tm_count[15:0]);
        break;
      end
    end
    do_write(2'd0, 1'b1, 16'h0000);
  endtask

  task automatic test_random();
    n_checks++;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        logic [15:0] d;
        logic        sel = 1'($urandom_range(0, 1));
        if (sel) begin
          d = 16'($urandom);
          d[1:0] = ($urandom_range(0, 7) == 0) ? 2'd2 : 2'($urandom_range(0, 1));
          d[7] = ($urandom_range(0, 3) != 0);
        end else begin
          d = ($urandom_range(0, 1) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
        end
        do_write(2'($urandom_range(0, 3)), sel, d);
      end else begin
        tick_clk();
      end
      if ({tm_count, overflow, timer_irq} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h", k, {tm_count, overflow, timer_irq}, exp_vec());
        break;
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      do_write(2'(i), 1'b0, 16'hFFF8);
      do_write(2'(i), 1'b1, 16'h00C0);
    end
    for (int k = 0; k < 10; k++) tick_clk();
    reset = 1'b1;
    wr_en = 1'b1; wr_timer = 2'd0; wr_sel = 1'b1; wr_data = 16'h00C0;
    tick_clk();
    wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0;
    reset = 1'b0;
    n_checks++;
    if ({tm_count, overflow, timer_irq} !== 72'h0) begin
      n_fail++; $display("FAIL reset_mid: got %h expected %h", {tm_count, overflow, timer_irq}, 72'h0);
    end
    n_checks++;
    for (int k = 0; k < 30; k++) begin
      tick_clk();
      if ({tm_count, overflow, timer_irq} !== 72'h0) begin
        n_fail++; $display("FAIL reset_idle[%0d]: got %h expected %h", k, {tm_count, overflow, timer_irq}, 72'h0);
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_timer = '0; wr_sel = 1'b0; wr_data = '0;
    test_reset();
    test_t0_wrap();
    test_cascade();
    test_disable();
    test_reload_wrap();
    test_irq_mask();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
